store_queue: RTL and testbench

//  Circular buffer holding in-flight stores in program order for the out-of-order LSU.

---
 rtl/lsu_pkg.sv | 35 +++
 rtl/age_comparator.sv | 20 ++
 rtl/store_queue.sv | 222 ++++++++++++++++++++++
 tb/tb_store_queue.sv | 307 ++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/lsu_pkg.sv
// Shared LSU types: store-queue entry layout, memory access size
// encoding and the size-to-byte-count helper.
package lsu_pkg;

   // Widths baked into sq_entry_t; store_queue parameters must match.
   localparam int SQ_XLEN      = 32;
   localparam int SQ_ROB_TAG_W = 5;

   typedef logic [1:0] mem_size_t;

   localparam mem_size_t MEM_BYTE = 2'b00;
   localparam mem_size_t MEM_HALF = 2'b01;
   localparam mem_size_t MEM_WORD = 2'b10;

   typedef struct packed {
      logic                    valid;
      logic                    addr_valid;
      logic                    committed;
      logic [SQ_ROB_TAG_W-1:0] rob_tag;
      logic [SQ_XLEN-1:0]      addr;
      logic [SQ_XLEN-1:0]      data;
      mem_size_t               size;
   } sq_entry_t;

   function automatic logic [2:0] size_bytes(input mem_size_t s);
      logic [2:0] n;
      case (s)
         MEM_BYTE: n = 3'd1;
         MEM_HALF: n = 3'd2;
         default:  n = 3'd4;
      endcase
      return n;
   endfunction

endpackage

// File: rtl/age_comparator.sv
// ROB-relative age compare: result=1 when b is older than a, with ages
// measured as distance from the ROB head (modulo 2**N).
// Ports: head, a, b (N bits each) in; result out.
module age_comparator #(
   parameter int N = 5
) (
   input  logic [N-1:0] head,
   input  logic [N-1:0] a,
   input  logic [N-1:0] b,
   output logic         result
);

   logic [N-1:0] a_off;
   logic [N-1:0] b_off;

   assign a_off  = a - head;
   assign b_off  = b - head;
   assign result = b_off < a_off;

endmodule

// File: rtl/store_queue.sv
// Store queue: circular buffer of in-flight stores with alloc/exec/commit/
// drain/flush and a combinational store-to-load forwarding search.
// Ports: alloc_* (dispatch), exec_* (address/data capture), commit_valid,
// mem_* (drain handshake), flush, rob_head, ld_* in and fwd_* out (forwarding).
module store_queue
   import lsu_pkg::*;
#(
   parameter int XLEN          = SQ_XLEN,
   parameter int SQ_SIZE       = 8,
   parameter int ROB_TAG_WIDTH = SQ_ROB_TAG_W
) (
   input  logic                       clk,
   input  logic                       reset,
   input  logic                       alloc_valid,
   input  logic [ROB_TAG_WIDTH-1:0]   alloc_rob_tag,
   output logic                       alloc_ready,
   output logic [$clog2(SQ_SIZE)-1:0] alloc_sq_idx,
   input  logic                       exec_valid,
   input  logic [$clog2(SQ_SIZE)-1:0] exec_sq_idx,
   input  logic [XLEN-1:0]            exec_addr,
   input  logic [XLEN-1:0]            exec_data,
   input  logic [1:0]                 exec_size,
   input  logic                       commit_valid,
   output logic                       mem_write_valid,
   input  logic                       mem_write_ready,
   output logic [XLEN-1:0]            mem_addr,
   output logic [XLEN-1:0]            mem_data,
   output logic [1:0]                 mem_size,
   input  logic                       flush,
   input  logic [ROB_TAG_WIDTH-1:0]   rob_head,
   input  logic                       ld_valid,
   input  logic [ROB_TAG_WIDTH-1:0]   ld_rob_tag,
   input  logic [XLEN-1:0]            ld_addr,
   input  logic [1:0]                 ld_size,
   output logic                       fwd_hit,
   output logic [XLEN-1:0]            fwd_data,
   output logic                       fwd_stall
);

   localparam int IW = $clog2(SQ_SIZE);
   localparam int PW = IW + 1;

   sq_entry_t entries_q [SQ_SIZE];
   sq_entry_t entries_d [SQ_SIZE];

   logic [PW-1:0] head_q, head_d;
   logic [PW-1:0] cmt_q, cmt_d;
   logic [PW-1:0] tail_q, tail_d;
   logic [PW-1:0] count;

   logic [IW-1:0] head_idx;
   logic [IW-1:0] cmt_idx;
   logic [IW-1:0] tail_idx;

   logic alloc_fire;
   logic commit_fire;
   logic drain_fire;

   logic [SQ_SIZE-1:0] older;

   logic [IW-1:0] scan_idx;
   logic [IW-1:0] sel_idx;
   logic          sel_found;
   logic          unk_older;
   sq_entry_t     sel_e;
   logic [1:0]    byte_off;
   logic [XLEN-1:0] shifted;

   function automatic logic [XLEN:0] hi_of(input logic [XLEN-1:0] a,
                                           input mem_size_t s);
      return {1'b0, a} + (XLEN+1)'(size_bytes(s));
   endfunction

   function automatic logic overlaps(input logic [XLEN-1:0] sa,
                                     input mem_size_t ss,
                                     input logic [XLEN-1:0] la,
                                     input mem_size_t ls);
      return ({1'b0, sa} < hi_of(la, ls)) && ({1'b0, la} < hi_of(sa, ss));
   endfunction

   function automatic logic covers(input logic [XLEN-1:0] sa,
                                   input mem_size_t ss,
                                   input logic [XLEN-1:0] la,
                                   input mem_size_t ls);
      return (sa <= la) && (hi_of(la, ls) <= hi_of(sa, ss));
   endfunction

   function automatic logic [XLEN-1:0] size_mask(input mem_size_t s);
      logic [XLEN-1:0] m;
      case (s)
         MEM_BYTE: m = {{(XLEN-8){1'b0}}, 8'hFF};
         MEM_HALF: m = {{(XLEN-16){1'b0}}, 16'hFFFF};
         default:  m = '1;
      endcase
      return m;
   endfunction

   assign head_idx = head_q[IW-1:0];
   assign cmt_idx  = cmt_q[IW-1:0];
   assign tail_idx = tail_q[IW-1:0];

   assign count        = tail_q - head_q;
   assign alloc_ready  = count != PW'(SQ_SIZE);
   assign alloc_sq_idx = tail_idx;

   assign mem_write_valid = entries_q[head_idx].valid &&
                            entries_q[head_idx].committed &&
                            entries_q[head_idx].addr_valid;
   assign mem_addr = entries_q[head_idx].addr;
   assign mem_data = entries_q[head_idx].data;
   assign mem_size = entries_q[head_idx].size;

   assign drain_fire  = mem_write_valid && mem_write_ready;
   assign alloc_fire  = alloc_valid && alloc_ready && !flush;
   assign commit_fire = commit_valid && (cmt_q != tail_q) && !flush;

   for (genvar g = 0; g < SQ_SIZE; g++) begin : g_age
      age_comparator #(.N(ROB_TAG_WIDTH)) u_age (
         .head   (rob_head),
         .a      (ld_rob_tag),
         .b      (entries_q[g].rob_tag),
         .result (older[g])
      );
   end

   always_comb begin
      entries_d = entries_q;
      head_d    = drain_fire  ? head_q + PW'(1) : head_q;
      cmt_d     = commit_fire ? cmt_q + PW'(1)  : cmt_q;
      tail_d    = alloc_fire  ? tail_q + PW'(1) : tail_q;

      if (flush) begin
         // Uncommitted entries are exactly those at or after commit_ptr.
         for (int i = 0; i < SQ_SIZE; i++) begin
            if (entries_q[i].valid && !entries_q[i].committed) begin
               entries_d[i] = '0;
            end
         end
         tail_d = cmt_q;
      end else begin
         if (exec_valid && entries_q[exec_sq_idx].valid) begin
            entries_d[exec_sq_idx].addr       = exec_addr;
            entries_d[exec_sq_idx].data       = exec_data;
            entries_d[exec_sq_idx].size       = exec_size;
            entries_d[exec_sq_idx].addr_valid = 1'b1;
         end
         if (commit_fire) begin
            entries_d[cmt_idx].committed = 1'b1;
         end
         if (alloc_fire) begin
            entries_d[tail_idx]         = '0;
            entries_d[tail_idx].valid   = 1'b1;
            entries_d[tail_idx].rob_tag = alloc_rob_tag;
         end
      end

      if (drain_fire) begin
         entries_d[head_idx] = '0;
      end
   end

   // Scan head->tail; later matches overwrite, leaving the youngest.
   always_comb begin
      unk_older = 1'b0;
      sel_found = 1'b0;
      sel_idx   = '0;
      scan_idx  = '0;
      for (int k = 0; k < SQ_SIZE; k++) begin
         scan_idx = head_idx + IW'(k);
         if (PW'(k) < count && entries_q[scan_idx].valid &&
             (entries_q[scan_idx].committed || older[scan_idx])) begin
            if (!entries_q[scan_idx].addr_valid) begin
               unk_older = 1'b1;
            end else if (overlaps(entries_q[scan_idx].addr,
                                  entries_q[scan_idx].size,
                                  ld_addr, ld_size)) begin
               sel_found = 1'b1;
               sel_idx   = scan_idx;
            end
         end
      end
   end

   assign sel_e    = entries_q[sel_idx];
   assign byte_off = ld_addr[1:0] - sel_e.addr[1:0];
   assign shifted  = sel_e.data >> {byte_off, 3'b000};

   always_comb begin
      fwd_hit   = 1'b0;
      fwd_stall = 1'b0;
      fwd_data  = '0;
      if (ld_valid) begin
         if (unk_older) begin
            fwd_stall = 1'b1;
         end else if (sel_found) begin
            if (covers(sel_e.addr, sel_e.size, ld_addr, ld_size)) begin
               fwd_hit  = 1'b1;
               fwd_data = shifted & size_mask(ld_size);
            end else begin
               fwd_stall = 1'b1;
            end
         end
      end
   end

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         for (int i = 0; i < SQ_SIZE; i++) begin
            entries_q[i] <= '0;
         end
         head_q <= '0;
         cmt_q  <= '0;
         tail_q <= '0;
      end else begin
         entries_q <= entries_d;
         head_q    <= head_d;
         cmt_q     <= cmt_d;
         tail_q    <= tail_d;
      end
   end

endmodule

// File: tb/tb_store_queue.sv
// Directed bench for store_queue: reset, full/drain, forwarding,
// flush and pointer wrap-around.
module tb_store_queue;
   import lsu_pkg::*;

   logic        clk;
   logic        reset;
   logic        alloc_valid;
   logic [4:0]  alloc_rob_tag;
   logic        alloc_ready;
   logic [2:0]  alloc_sq_idx;
   logic        exec_valid;
   logic [2:0]  exec_sq_idx;
   logic [31:0] exec_addr;
   logic [31:0] exec_data;
   logic [1:0]  exec_size;
   logic        commit_valid;
   logic        mem_write_valid;
   logic        mem_write_ready;
   logic [31:0] mem_addr;
   logic [31:0] mem_data;
   logic [1:0]  mem_size;
   logic        flush;
   logic [4:0]  rob_head;
   logic        ld_valid;
   logic [4:0]  ld_rob_tag;
   logic [31:0] ld_addr;
   logic [1:0]  ld_size;
   logic        fwd_hit;
   logic [31:0] fwd_data;
   logic        fwd_stall;

   int n_pass   = 0;
   int n_checks = 0;

   store_queue #(.XLEN(32), .SQ_SIZE(8), .ROB_TAG_WIDTH(5)) dut (
      .clk             (clk),
      .reset           (reset),
      .alloc_valid     (alloc_valid),
      .alloc_rob_tag   (alloc_rob_tag),
      .alloc_ready     (alloc_ready),
      .alloc_sq_idx    (alloc_sq_idx),
      .exec_valid      (exec_valid),
      .exec_sq_idx     (exec_sq_idx),
      .exec_addr       (exec_addr),
      .exec_data       (exec_data),
      .exec_size       (exec_size),
      .commit_valid    (commit_valid),
      .mem_write_valid (mem_write_valid),
      .mem_write_ready (mem_write_ready),
      .mem_addr        (mem_addr),
      .mem_data        (mem_data),
      .mem_size        (mem_size),
      .flush           (flush),
      .rob_head        (rob_head),
      .ld_valid        (ld_valid),
      .ld_rob_tag      (ld_rob_tag),
      .ld_addr         (ld_addr),
      .ld_size         (ld_size),
      .fwd_hit         (fwd_hit),
      .fwd_data        (fwd_data),
      .fwd_stall       (fwd_stall)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   initial begin
      #200000;
      $display("FAIL watchdog: observed timeout required finish");
      $fatal(1, "watchdog");
   end

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic chk1(input string name, input logic obs, input logic exp);
      n_checks++;
      assert (obs === exp) n_pass++;
      else $error("FAIL %s: observed %b required %b", name, obs, exp);
   endtask

   task automatic chk32(input string name, input logic [31:0] obs,
                        input logic [31:0] exp);
      n_checks++;
      assert (obs === exp) n_pass++;
      else $error("FAIL %s: observed %h required %h", name, obs, exp);
   endtask

   task automatic do_alloc(input logic [4:0] tag);
      alloc_valid   = 1'b1;
      alloc_rob_tag = tag;
      step();
      alloc_valid   = 1'b0;
   endtask

   task automatic do_exec(input logic [2:0] idx, input logic [31:0] a,
                          input logic [31:0] d, input logic [1:0] sz);
      exec_valid  = 1'b1;
      exec_sq_idx = idx;
      exec_addr   = a;
      exec_data   = d;
      exec_size   = sz;
      step();
      exec_valid  = 1'b0;
   endtask

   task automatic do_commit();
      commit_valid = 1'b1;
      step();
      commit_valid = 1'b0;
   endtask

   task automatic do_reset();
      reset = 1'b1;
      step();
      reset = 1'b0;
      #1;
   endtask

   task automatic load(input logic [4:0] tag, input logic [31:0] a,
                       input logic [1:0] sz);
      ld_valid   = 1'b1;
      ld_rob_tag = tag;
      ld_addr    = a;
      ld_size    = sz;
      #1;
   endtask

   initial begin
      reset = 1'b1;
      alloc_valid = 0; alloc_rob_tag = 0;
      exec_valid = 0; exec_sq_idx = 0; exec_addr = 0;
      exec_data = 0; exec_size = 0;
      commit_valid = 0; mem_write_ready = 0; flush = 0;
      rob_head = 0; ld_valid = 0; ld_rob_tag = 0;
      ld_addr = 0; ld_size = 0;
      step();
      step();
      reset = 1'b0;
      #1;

      // reset state
      chk1 ("rst_alloc_ready", alloc_ready, 1'b1);
      chk32("rst_alloc_idx", 32'(alloc_sq_idx), 32'd0);
      chk1 ("rst_mem_valid", mem_write_valid, 1'b0);
      chk1 ("rst_fwd_hit", fwd_hit, 1'b0);
      chk1 ("rst_fwd_stall", fwd_stall, 1'b0);
      chk32("rst_fwd_data", fwd_data, 32'd0);

      // reset mid-operation with 3 entries
      do_alloc(5'd0);
      do_alloc(5'd1);
      do_alloc(5'd2);
      do_exec(3'd0, 32'h10, 32'h11, MEM_WORD);
      do_commit();
      chk1 ("mid_mem_valid", mem_write_valid, 1'b1);
      chk32("mid_alloc_idx", 32'(alloc_sq_idx), 32'd3);
      do_reset();
      chk1 ("mid_rst_ready", alloc_ready, 1'b1);
      chk1 ("mid_rst_mem_valid", mem_write_valid, 1'b0);
      chk32("mid_rst_idx", 32'(alloc_sq_idx), 32'd0);

      // fill, then drain while full
      do_alloc(5'd0);
      do_exec(3'd0, 32'h40, 32'hA5A5A5A5, MEM_WORD);
      do_commit();
      for (int i = 1; i < 8; i++) do_alloc(5'(i));
      chk1 ("full_ready", alloc_ready, 1'b0);
      chk32("full_idx", 32'(alloc_sq_idx), 32'd0);
      chk1 ("full_mem_valid", mem_write_valid, 1'b1);
      chk32("full_mem_addr", mem_addr, 32'h40);
      chk32("full_mem_data", mem_data, 32'hA5A5A5A5);
      mem_write_ready = 1'b1;
      alloc_valid     = 1'b1;
      alloc_rob_tag   = 5'd8;
      #1;
      chk1 ("pop_same_cycle_ready", alloc_ready, 1'b0);
      step();
      mem_write_ready = 1'b0;
      alloc_valid     = 1'b0;
      chk1 ("pop_next_ready", alloc_ready, 1'b1);
      chk32("pop_next_idx", 32'(alloc_sq_idx), 32'd0);
      chk1 ("pop_next_mem_valid", mem_write_valid, 1'b0);

      // word store forwarded to byte/half loads
      do_reset();
      rob_head = 5'd0;
      do_alloc(5'd1);
      do_exec(3'd0, 32'h100, 32'hDEADBEEF, MEM_WORD);
      load(5'd3, 32'h102, MEM_BYTE);
      chk1 ("fw_b_hit", fwd_hit, 1'b1);
      chk1 ("fw_b_stall", fwd_stall, 1'b0);
      chk32("fw_b_data", fwd_data, 32'h000000AD);
      load(5'd3, 32'h101, MEM_HALF);
      chk1 ("fw_h_hit", fwd_hit, 1'b1);
      chk32("fw_h_data", fwd_data, 32'h0000ADBE);
      load(5'd3, 32'h104, MEM_BYTE);
      chk1 ("fw_miss_hit", fwd_hit, 1'b0);
      chk1 ("fw_miss_stall", fwd_stall, 1'b0);
      ld_valid = 1'b0;

      // unknown older address, younger store ignored
      do_alloc(5'd2);
      do_alloc(5'd5);
      do_exec(3'd2, 32'h500, 32'h77, MEM_BYTE);
      load(5'd3, 32'h102, MEM_BYTE);
      chk1 ("unk_stall", fwd_stall, 1'b1);
      chk1 ("unk_hit", fwd_hit, 1'b0);
      ld_valid = 1'b0;
      do_exec(3'd1, 32'h300, 32'h0, MEM_WORD);
      load(5'd3, 32'h102, MEM_BYTE);
      chk1 ("res_hit", fwd_hit, 1'b1);
      chk32("res_data", fwd_data, 32'h000000AD);
      load(5'd3, 32'h500, MEM_BYTE);
      chk1 ("young_hit", fwd_hit, 1'b0);
      chk1 ("young_stall", fwd_stall, 1'b0);
      load(5'd6, 32'h500, MEM_BYTE);
      chk1 ("old_hit", fwd_hit, 1'b1);
      chk32("old_data", fwd_data, 32'h00000077);
      ld_valid = 1'b0;
      #1;
      chk32("ld_idle_data", fwd_data, 32'd0);

      // partial overlap
      do_reset();
      do_alloc(5'd0);
      do_exec(3'd0, 32'h200, 32'h5A, MEM_BYTE);
      load(5'd2, 32'h200, MEM_WORD);
      chk1 ("part_stall", fwd_stall, 1'b1);
      chk1 ("part_hit", fwd_hit, 1'b0);
      load(5'd2, 32'h200, MEM_BYTE);
      chk1 ("part_b_hit", fwd_hit, 1'b1);
      chk32("part_b_data", fwd_data, 32'h0000005A);
      ld_valid = 1'b0;

      // flush with two committed entries, then drain in order
      do_reset();
      for (int i = 0; i < 4; i++) do_alloc(5'(i));
      for (int i = 0; i < 4; i++)
         do_exec(3'(i), 32'h600 + 32'(4*i), 32'h1000 + 32'(i), MEM_WORD);
      chk1 ("fl_pre_valid", mem_write_valid, 1'b0);
      do_commit();
      chk1 ("fl_cmt_latency", mem_write_valid, 1'b1);
      do_commit();
      flush = 1'b1;
      step();
      flush = 1'b0;
      chk32("fl_tail", 32'(alloc_sq_idx), 32'd2);
      load(5'd7, 32'h608, MEM_WORD);
      chk1 ("fl_gone_hit", fwd_hit, 1'b0);
      chk1 ("fl_gone_stall", fwd_stall, 1'b0);
      load(5'd7, 32'h604, MEM_WORD);
      chk1 ("fl_kept_hit", fwd_hit, 1'b1);
      chk32("fl_kept_data", fwd_data, 32'h1001);
      ld_valid = 1'b0;
      chk32("fl_d0_addr", mem_addr, 32'h600);
      step();
      chk32("fl_d0_stable", mem_data, 32'h1000);
      mem_write_ready = 1'b1;
      step();
      chk1 ("fl_d1_valid", mem_write_valid, 1'b1);
      chk32("fl_d1_addr", mem_addr, 32'h604);
      chk32("fl_d1_data", mem_data, 32'h1001);
      step();
      mem_write_ready = 1'b0;
      chk1 ("fl_done_valid", mem_write_valid, 1'b0);
      chk32("fl_done_idx", 32'(alloc_sq_idx), 32'd2);

      // wrap-around of queue index and ROB tags
      do_reset();
      for (int i = 0; i < 6; i++) begin
         do_alloc(5'(i));
         do_exec(3'(i), 32'h800, 32'(i), MEM_WORD);
         do_commit();
         mem_write_ready = 1'b1;
         step();
         mem_write_ready = 1'b0;
      end
      chk32("wr_head_idx", 32'(alloc_sq_idx), 32'd6);
      chk1 ("wr_empty", mem_write_valid, 1'b0);
      rob_head = 5'd30;
      do_alloc(5'd30);
      do_alloc(5'd31);
      do_alloc(5'd0);
      do_alloc(5'd2);
      chk32("wr_tail_idx", 32'(alloc_sq_idx), 32'd2);
      do_exec(3'd6, 32'h700, 32'h11111111, MEM_WORD);
      do_exec(3'd7, 32'h700, 32'h22222222, MEM_WORD);
      do_exec(3'd0, 32'h700, 32'h33333333, MEM_WORD);
      do_exec(3'd1, 32'h700, 32'h44444444, MEM_WORD);
      load(5'd1, 32'h700, MEM_WORD);
      chk1 ("wr_hit", fwd_hit, 1'b1);
      chk32("wr_data", fwd_data, 32'h33333333);
      load(5'd31, 32'h700, MEM_WORD);
      chk32("wr_first_data", fwd_data, 32'h11111111);
      load(5'd3, 32'h700, MEM_WORD);
      chk32("wr_last_data", fwd_data, 32'h44444444);
      ld_valid = 1'b0;

      $display("%0d/%0d checks passed", n_pass, n_checks);
      $finish;
   end

endmodule
